// File: rtl/video_timing_ctrl_if.sv
// Pixel stream handshake between an upstream source (line FIFO) and the
// video timing controller. The source drives data/valid; the controller
// drives ready on every visible pixel and never stalls.
interface video_timing_ctrl_if;
    logic [23:0] pix_data;   // {R[23:16], G[15:8], B[7:0]}
    logic        pix_valid;
    logic        pix_ready;

    modport master (output pix_data, output pix_valid, input  pix_ready);
    modport slave  (input  pix_data, input  pix_valid, output pix_ready);
endinterface

// File: rtl/video_timing_ctrl.sv
// Raster sequencer for the HDMI encoder: free-running h/v counters,
// sync/vde generation, pixel pull from the upstream stream, and a sticky
// underflow flag with a substitute colour. Everything is one pixel clock.
module video_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter logic [23:0] UF_COLOR = 24'hFF00FF
) (
    input  logic                 pixel_clk,
    input  logic                 reset_n,
    input  logic                 enable,
    video_timing_ctrl_if.slave   pix_if,
    output logic                 frame_start,
    output logic [11:0]          pix_x,
    output logic [11:0]          pix_y,
    output logic [7:0]           red,
    output logic [7:0]           green,
    output logic [7:0]           blue,
    output logic                 vde,
    output logic                 hsync,
    output logic                 vsync,
    input  logic                 underflow_clr,
    output logic                 underflow
);

    // Totals must fit the 12-bit counters (<= 4096).
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    // Sync window bounds are 13 bits so an end of exactly 4096 still compares correctly.
    localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic        r_vde;
    logic        r_hsync;
    logic        r_vsync;
    logic [23:0] r_rgb;
    logic        r_underflow;

    logic        w_active;
    logic        w_pix_ready;
    logic        w_hs_on;
    logic        w_vs_on;
    logic        w_underrun;
    logic [23:0] w_rgb_next;

    // Counters are forced to 0 while disabled, so gating with enable keeps
    // the held h=0/v=0 position from looking like a visible pixel.
    assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_pix_ready = enable && w_active;
    assign w_hs_on     = enable && ({1'b0, r_h_cnt} >= HS_BEG) && ({1'b0, r_h_cnt} < HS_END);
    assign w_vs_on     = enable && ({1'b0, r_v_cnt} >= VS_BEG) && ({1'b0, r_v_cnt} < VS_END);
    assign w_underrun  = w_pix_ready && !pix_if.pix_valid;

    assign pix_if.pix_ready = w_pix_ready;
    assign frame_start      = enable && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    assign pix_x            = r_h_cnt;
    assign pix_y            = r_v_cnt;
    assign {red, green, blue} = r_rgb;
    assign vde              = r_vde;
    assign hsync            = r_hsync;
    assign vsync            = r_vsync;
    assign underflow        = r_underflow;

    // Raster position: h wraps every line, v advances on the h wrap; disable abandons the frame.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    // Pixel colour for this position: accepted data, substitute colour on underrun, black in blanking.
    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no latch is inferred.
        w_rgb_next = 24'h000000;
        if (w_pix_ready) begin
            w_rgb_next = pix_if.pix_valid ? pix_if.pix_data : UF_COLOR;
        end
    end

    // Encoder-facing register stage: vde, syncs and RGB stay mutually aligned, one cycle behind the counters.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vde   <= 1'b0;
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
            r_rgb   <= '0;
        end else begin
            r_vde   <= w_pix_ready;
            r_hsync <= w_hs_on ? HS_POL : ~HS_POL;
            r_vsync <= w_vs_on ? VS_POL : ~VS_POL;
            r_rgb   <= w_rgb_next;
        end
    end

    // Sticky underflow flag; a new underrun beats a simultaneous clear.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow <= 1'b0;
        end else if (w_underrun) begin
            r_underflow <= 1'b1;
        end else if (underflow_clr) begin
            r_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl. A small-raster instance (8x6 total) is checked
// every cycle against a frame-position model; a default-parameter instance is
// checked while idle. Directed phases pin the model with hand-computed values.
module tb_video_timing_ctrl;

    localparam int HT = 8;          // 4+1+2+1
    localparam int VT = 6;          // 3+1+1+1
    localparam int FT = HT * VT;    // 48 cycles per frame

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n       = 1'b0;
    logic enable        = 1'b0;
    logic underflow_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- small-raster DUT ----------------
    video_timing_ctrl_if s_if ();
    logic        fs, vde, hsync, vsync, uf;
    logic [11:0] px, py;
    logic [7:0]  red, green, blue;

    video_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .UF_COLOR(24'hFF00FF)
    ) u_small (
        .pixel_clk(clk), .reset_n(reset_n), .enable(enable), .pix_if(s_if.slave),
        .frame_start(fs), .pix_x(px), .pix_y(py),
        .red(red), .green(green), .blue(blue),
        .vde(vde), .hsync(hsync), .vsync(vsync),
        .underflow_clr(underflow_clr), .underflow(uf)
    );

    // ---------------- default-parameter DUT (held idle) ----------------
    video_timing_ctrl_if d_if ();
    logic        d_enable = 1'b0;
    logic        d_clr    = 1'b0;
    logic        d_fs, d_vde, d_hs, d_vs, d_uf;
    logic [11:0] d_px, d_py;
    logic [7:0]  d_r, d_g, d_b;

    video_timing_ctrl u_dflt (
        .pixel_clk(clk), .reset_n(reset_n), .enable(d_enable), .pix_if(d_if.slave),
        .frame_start(d_fs), .pix_x(d_px), .pix_y(d_py),
        .red(d_r), .green(d_g), .blue(d_b),
        .vde(d_vde), .hsync(d_hs), .vsync(d_vs),
        .underflow_clr(d_clr), .underflow(d_uf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The raster is tracked as a single position t within the 48-cycle frame
    // (cycles since enable); h/v and all windows are derived arithmetically.
    function automatic bit f_act(input int t);
        return ((t % HT) < 4) && ((t / HT) < 3);
    endfunction
    function automatic bit f_hs(input int t);
        return ((t % HT) >= 5) && ((t % HT) < 7);
    endfunction
    function automatic bit f_vs(input int t);
        return (t / HT) == 4;
    endfunction

    int          m_t   = 0;
    logic        e_vde = 1'b0;
    logic        e_hs  = 1'b1;
    logic        e_vs  = 1'b1;
    logic [23:0] e_rgb = 24'h0;
    logic        e_uf  = 1'b0;

    // Model advance: registered expectations come from the position and inputs of the cycle just ended.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_t   <= 0;
            e_vde <= 1'b0;
            e_hs  <= 1'b1;
            e_vs  <= 1'b1;
            e_rgb <= 24'h0;
            e_uf  <= 1'b0;
        end else begin
            e_vde <= enable && f_act(m_t);
            e_hs  <= !(enable && f_hs(m_t));
            e_vs  <= !(enable && f_vs(m_t));
            e_rgb <= !(enable && f_act(m_t)) ? 24'h0 :
                     (s_if.pix_valid ? s_if.pix_data : 24'hFF00FF);
            if (enable && f_act(m_t) && !s_if.pix_valid) e_uf <= 1'b1;
            else if (underflow_clr)                      e_uf <= 1'b0;
            m_t <= enable ? (m_t + 1) % FT : 0;
        end
    end

    // Compare process: every cycle, mid-period, all small-DUT outputs against the model.
    always @(negedge clk) begin
        check("pix_ready",   32'(s_if.pix_ready), 32'(enable && f_act(m_t)));
        check("frame_start", 32'(fs),             32'(enable && (m_t == 0)));
        check("pix_x",       32'(px),             32'(m_t % HT));
        check("pix_y",       32'(py),             32'(m_t / HT));
        check("vde",         32'(vde),            32'(e_vde));
        check("hsync",       32'(hsync),          32'(e_hs));
        check("vsync",       32'(vsync),          32'(e_vs));
        check("rgb",         32'({red, green, blue}), 32'(e_rgb));
        check("underflow",   32'(uf),             32'(e_uf));
    end

    // One clock of stimulus: inputs change just after the edge, then wait to mid-period.
    task automatic cyc(input logic en, input logic val, input logic clr);
        @(posedge clk);
        #1;
        enable        = en;
        s_if.pix_valid = val;
        underflow_clr = clr;
        s_if.pix_data = s_if.pix_data + 24'h010203;
        @(negedge clk);
    endtask

    logic [23:0] d0;
    int fs_cnt, fs_first, fs_second, vde_cnt, vs_low, hs_low, hs_first;

    initial begin
        s_if.pix_data  = 24'h0;
        s_if.pix_valid = 1'b0;
        d_if.pix_data  = 24'h0;
        d_if.pix_valid = 1'b0;

        // Reset, then 100 idle cycles.
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            check("idle_vde",   32'(d_vde), 32'd0);
            check("idle_hsync", 32'(d_hs),  32'd1);
            check("idle_vsync", 32'(d_vs),  32'd1);
            check("idle_rgb",   32'({d_r, d_g, d_b}), 32'd0);
            check("idle_ready", 32'(d_if.pix_ready), 32'd0);
        end

        // Two full frames with continuous valid data.
        fs_cnt = 0; fs_first = -1; fs_second = -1;
        vde_cnt = 0; vs_low = 0; hs_low = 0; hs_first = -1;
        d0 = 24'h0;
        for (int i = 0; i < 2 * FT; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (i == 0) d0 = s_if.pix_data;
            if (i == 1) check("first_pixel", 32'({red, green, blue}), 32'(d0));
            if (fs) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if (i >= 1 && i <= FT) begin
                vde_cnt += int'(vde);
                vs_low  += int'(!vsync);
            end
            if (i >= 1 && i <= HT) begin
                hs_low += int'(!hsync);
                if (!hsync && hs_first < 0) hs_first = i;
            end
        end
        check("fs_count",     32'(fs_cnt),    32'd2);
        check("fs_first",     32'(fs_first),  32'd0);
        check("fs_period",    32'(fs_second - fs_first), 32'd48);
        check("vde_per_frame", 32'(vde_cnt),  32'd12);
        check("vsync_low",    32'(vs_low),    32'd8);
        check("hsync_low",    32'(hs_low),    32'd2);
        check("hsync_start",  32'(hs_first),  32'd6);

        // Underflow at position 9, clear at 15, clear+underflow together at 17.
        for (int j = 0; j < 19; j++) begin
            cyc(1'b1, !(j == 9 || j == 17), (j == 15 || j == 17));
            if (j == 9)  check("uf_before",   32'(uf), 32'd0);
            if (j == 10) begin
                check("uf_color", 32'({red, green, blue}), 32'hFF00FF);
                check("uf_set",   32'(uf), 32'd1);
            end
            if (j == 14) check("uf_sticky",   32'(uf), 32'd1);
            if (j == 16) check("uf_cleared",  32'(uf), 32'd0);
            if (j == 18) check("uf_set_wins", 32'(uf), 32'd1);
        end

        // Run on to h=2, v=1 of the next frame (positions 19..47, 0..9).
        repeat (39) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check("drop_ready", 32'(s_if.pix_ready), 32'd0);
        check("drop_fs",    32'(fs), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        check("drop_x",   32'(px),  32'd0);
        check("drop_y",   32'(py),  32'd0);
        check("drop_vde", 32'(vde), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("reenable_fs", 32'(fs), 32'd1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("pre_rst_vde", 32'(vde), 32'd1);
        check("pre_rst_uf",  32'(uf),  32'd1);

        // Asynchronous reset in the middle of a visible line.
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_vde",   32'(vde),   32'd0);
        check("arst_hsync", 32'(hsync), 32'd1);
        check("arst_vsync", 32'(vsync), 32'd1);
        check("arst_rgb",   32'({red, green, blue}), 32'd0);
        check("arst_uf",    32'(uf),    32'd0);
        check("arst_x",     32'(px),    32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Sequencer for the TMDS/HDMI output path: generates the raster counters, `hsync`/`vsync`/`vde` and the pixel-fetch handshake that feed the HDMI encoder's `red/green/blue/vde/hsync/vsync` inputs, all in the pixel clock domain. It pulls pixels from an upstream stream source (typically a line FIFO) through a valid/ready handshake. It substitutes a fixed colour and flags a sticky error on underflow. It sits between the frame-buffer/FIFO logic and the HDMI encoder.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level
- `UF_COLOR`, 24'hFF00FF, RGB emitted on underflow

Ports:
- `pixel_clk` in 1: pixel clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run raster; low holds the block idle.
- `pix_data` in 24: upstream pixel {R[23:16],G[15:8],B[7:0]}.
- `pix_valid` in 1: `pix_data` valid.
- `pix_ready` out 1: controller consumes a pixel this cycle.
- `frame_start` out 1: one-cycle pulse, first cycle of a frame.
- `pix_x` out 12: current horizontal counter.
- `pix_y` out 12: current vertical counter.
- `red`, `green`, `blue` out 8 each: to encoder.
- `vde`, `hsync`, `vsync` out 1 each: to encoder.
- `underflow_clr` in 1: clears `underflow`.
- `underflow` out 1: sticky underflow flag.

## Operation
- Counters: `h_cnt` 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. `v_cnt` 0..V_TOTAL-1, where V_TOTAL is defined the same way. Both are 12-bit; parameter totals must be ≤4096. `h_cnt` wraps to 0 at H_TOTAL-1. `v_cnt` increments on the `h_cnt` wrap and wraps to 0 at V_TOTAL-1.
- `pix_x`/`pix_y` are the raw counter values.
- Active region: `h_cnt<H_ACTIVE && v_cnt<V_ACTIVE`.
- `pix_ready` is combinational: `enable && active`. A pixel is consumed on every active cycle whether or not `pix_valid` is high. No back-pressure exists; the raster never stalls.
- Hsync is asserted when `h_cnt` is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- Vsync is asserted when `v_cnt` is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines. Because `v_cnt` changes at `h_cnt`=0, vsync edges align to line starts.
- Output is `HS_POL`/`VS_POL` when asserted, and their inverse otherwise.
- `frame_start` is combinational: `enable && h_cnt==0 && v_cnt==0`.
- Output register stage: on every clock, `vde`, `hsync`, `vsync` and RGB are registered from the current counter state.
  - RGB is `pix_data` when `pix_ready && pix_valid`.
  - RGB is `UF_COLOR` when `pix_ready && !pix_valid`.
  - RGB is 0 when not active.
- Underflow flag: set when `pix_ready && !pix_valid`; cleared by `underflow_clr`. If both occur in the same cycle, set wins.
- Enable behaviour:
  - While `enable`=0, counters are held at 0, `pix_ready`=0 and `frame_start`=0. Registered outputs go to blanking: `vde`=0, syncs inactive, RGB=0.
  - The first cycle with `enable`=1 is h=0, v=0, so `frame_start` pulses.
  - Deasserting `enable` mid-frame zeroes the counters on the next edge; the frame is abandoned and no partial line is completed.

## Timing
- Reset values: `h_cnt`=`v_cnt`=0, `vde`=0, `hsync`=~HS_POL, `vsync`=~VS_POL, RGB=0, `underflow`=0.
- Combinational outputs follow the counters: `pix_ready`=0 and `frame_start`=0 while `enable`=0.
- Latency: 1 cycle from counter state (and the `pix_ready` handshake) to `vde`/syncs/RGB. All three registered control signals are mutually aligned and aligned with the RGB they qualify.
- The pixel accepted on the cycle `pix_ready`=1 appears on RGB, with `vde`=1, on the next cycle.
- `underflow` rises 1 cycle after the offending cycle.
- Registered vsync/hsync toggle 1 cycle after the corresponding counter boundary.

## Test plan
- **Reset/idle:** Use defaults. Hold `reset_n`=0, then release with `enable`=0 for 100 cycles. Required: `vde`=0, `hsync`=`vsync`=1, RGB=0 and `pix_ready`=0 throughout.
- **Small raster counts:** Set H=4/1/2/1 and V=3/1/1/1 (totals 8×6), hold `pix_valid`=1 and feed an incrementing `pix_data`.
  - `frame_start` pulses every 48 cycles.
  - `vde` is high 12 cycles per frame, in runs of 4 per line.
  - `hsync` is low 2 cycles per line, starting 6 cycles after the line's first `pix_ready` (register latency included).
  - `vsync` is low for exactly 8 cycles per frame.
- **Pixel ordering:** Using the same configuration, RGB values observed with `vde`=1 equal the `pix_data` sequence accepted, with no loss or duplication.
- **Underflow:** Drop `pix_valid` for 1 active cycle. Required:
  - RGB is FF00FF on that pixel.
  - `underflow` is set the next cycle and stays set.
  - Pulsing `underflow_clr` clears it.
  - Issuing `underflow_clr` in the same cycle as a new underflow leaves it set.
- **Enable drop mid-line:** Deassert `enable` at h=2, v=1 for 3 cycles, then re-enable. Required:
  - Counters read 0 on the next edge.
  - `vde`=0 one cycle later.
  - `frame_start` pulses on the first re-enabled cycle.
- **Async reset mid-frame:** Assert `reset_n` low asynchronously during an active line. All outputs take their reset values immediately, without waiting for a clock edge.
